// File: rtl/stack_pkg.sv
// Shared constants and command encoding for the four-entry stack datapath.
// The command enum packs {push,pop} so a single case can decode the controller.
package stack_pkg;
    localparam int STACK_DEPTH  = 4;
    localparam int STACK_ADDR_W = 2;
    localparam int STACK_DATA_W = 8;
    localparam int STACK_CNT_W  = 3;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_PUSH = 2'b10,
        CMD_POP  = 2'b01,
        CMD_BOTH = 2'b11
    } cmd_e;

    function automatic cmd_e to_cmd(input logic push, input logic pop);
        return cmd_e'({push, pop});
    endfunction
endpackage

// File: rtl/stack_store_if.sv
// Controller-to-storage bundle: commands and address in, read data and status out.
// The controller drives on the falling edge; storage samples on the rising edge.
interface stack_store_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
);
    logic              push;
    logic              pop;
    logic              A1;
    logic              A0;
    logic [DATA_W-1:0] Din;
    logic [DATA_W-1:0] Dout;
    logic              DoutValid;
    logic [DATA_W-1:0] Top;
    logic              TopValid;
    logic [CNT_W-1:0]  Count;
    logic              Full;
    logic              Empty;
    logic              OvfHit;
    logic              UnfHit;
    logic              AddrErr;
    logic              ProtoErr;

    modport master (
        output push, pop, A1, A0, Din,
        input  Dout, DoutValid, Top, TopValid, Count, Full, Empty,
               OvfHit, UnfHit, AddrErr, ProtoErr
    );

    modport slave (
        input  push, pop, A1, A0, Din,
        output Dout, DoutValid, Top, TopValid, Count, Full, Empty,
               OvfHit, UnfHit, AddrErr, ProtoErr
    );
endinterface

// File: rtl/stack_cmd_check.sv
// Combinational command legality check against the storage's own occupancy.
// Zero latency; exactly one outcome flag is raised per non-idle command.
module stack_cmd_check
    import stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int CNT_W = STACK_CNT_W
) (
    input  logic                    push,
    input  logic                    pop,
    input  logic [STACK_ADDR_W-1:0] addr,
    input  logic [CNT_W-1:0]        count,
    output logic                    accept_push,
    output logic                    accept_pop,
    output logic                    ovf,
    output logic                    unf,
    output logic                    addr_err,
    output logic                    proto_err
);
    cmd_e             cmd;
    logic [CNT_W-1:0] addr_ext;

    assign cmd      = to_cmd(push, pop);
    assign addr_ext = CNT_W'(addr);

    always_comb begin
        accept_push = 1'b0;
        accept_pop  = 1'b0;
        ovf         = 1'b0;
        unf         = 1'b0;
        addr_err    = 1'b0;
        proto_err   = 1'b0;
        case (cmd)
            CMD_BOTH: proto_err = 1'b1;
            // Saturation is checked before the address so a stale address while full is not an address fault.
            CMD_PUSH: begin
                if (count == CNT_W'(DEPTH))  ovf         = 1'b1;
                else if (addr_ext != count)  addr_err    = 1'b1;
                else                         accept_push = 1'b1;
            end
            CMD_POP: begin
                if (count == '0)                           unf        = 1'b1;
                else if (addr_ext != (count - CNT_W'(1)))  addr_err   = 1'b1;
                else                                       accept_pop = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/stack_store.sv
// Storage end of the push/pop stack: entries, occupancy count, read register and error flags.
// Pop data appears one cycle after the accepting edge; Top reflects writes the cycle after acceptance.
module stack_store
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int CNT_W  = STACK_CNT_W
) (
    input logic          Clk,
    input logic          Rst,
    stack_store_if.slave bus
);
    logic [STACK_ADDR_W-1:0] addr;
    logic [STACK_ADDR_W-1:0] top_idx;
    logic                    accept_push, accept_pop, ovf, unf, addr_err, proto_err;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              addr_err_q, addr_err_d;
    logic              proto_err_q, proto_err_d;

    assign addr    = {bus.A1, bus.A0};
    assign top_idx = STACK_ADDR_W'(count_q - CNT_W'(1));

    stack_cmd_check #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_cmd_check (
        .push        (bus.push),
        .pop         (bus.pop),
        .addr        (addr),
        .count       (count_q),
        .accept_push (accept_push),
        .accept_pop  (accept_pop),
        .ovf         (ovf),
        .unf         (unf),
        .addr_err    (addr_err),
        .proto_err   (proto_err)
    );

    always_comb begin
        mem_d       = mem_q;
        count_d     = count_q;
        dout_d      = dout_q;
        dout_vld_d  = accept_pop;
        ovf_d       = ovf;
        unf_d       = unf;
        addr_err_d  = addr_err_q | addr_err;
        proto_err_d = proto_err_q | proto_err;
        if (accept_push) begin
            mem_d[addr] = bus.Din;
            count_d     = count_q + CNT_W'(1);
        end
        // Popped entries stay in place; only the count moves.
        if (accept_pop) begin
            dout_d  = mem_q[addr];
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            addr_err_q  <= addr_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.Dout      = dout_q;
    assign bus.DoutValid = dout_vld_q;
    assign bus.Top       = (count_q == '0) ? '0 : mem_q[top_idx];
    assign bus.TopValid  = (count_q != '0);
    assign bus.Count     = count_q;
    assign bus.Full      = (count_q == CNT_W'(DEPTH));
    assign bus.Empty     = (count_q == '0);
    assign bus.OvfHit    = ovf_q;
    assign bus.UnfHit    = unf_q;
    assign bus.AddrErr   = addr_err_q;
    assign bus.ProtoErr  = proto_err_q;
endmodule

// File: tb/tb_stack_store.sv
// Directed bench for stack_store: commands driven on the falling edge, outputs checked 1ns after the rising edge.
module tb_stack_store;
    logic Clk;
    logic Rst;
    int   checks;
    int   failures;

    stack_store_if #(.DATA_W(8), .CNT_W(3)) bus ();

    stack_store #(.DATA_W(8), .DEPTH(4), .CNT_W(3)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [1:0] a, input logic [7:0] d);
        @(negedge Clk);
        bus.push = p;
        bus.pop  = q;
        bus.A1   = a[1];
        bus.A0   = a[0];
        bus.Din  = d;
        @(posedge Clk);
        #1;
    endtask

    logic [7:0] vals [4];

    initial begin
        checks   = 0;
        failures = 0;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        bus.push = 1'b0; bus.pop = 1'b0; bus.A1 = 1'b0; bus.A0 = 1'b0; bus.Din = '0;
        Rst = 1'b1;
        #12;
        chk("rst_count", 32'(bus.Count), 0);
        chk("rst_empty", 32'(bus.Empty), 1);
        chk("rst_full", 32'(bus.Full), 0);
        chk("rst_topvalid", 32'(bus.TopValid), 0);
        chk("rst_dout", 32'(bus.Dout), 0);
        chk("rst_flags", 32'({bus.DoutValid, bus.OvfHit, bus.UnfHit, bus.AddrErr, bus.ProtoErr}), 0);
        @(negedge Clk);
        Rst = 1'b0;

        // Fill 0x11..0x44
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'(i), vals[i]);
            chk("push_count", 32'(bus.Count), 32'(i + 1));
            chk("push_top", 32'(bus.Top), 32'(vals[i]));
        end
        chk("fill_full", 32'(bus.Full), 1);
        chk("fill_errs", 32'({bus.AddrErr, bus.ProtoErr, bus.OvfHit}), 0);

        // Drain in LIFO order
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, 2'(i), 8'h00);
            chk("pop_dout", 32'(bus.Dout), 32'(vals[i]));
            chk("pop_dvld", 32'(bus.DoutValid), 1);
            chk("pop_count", 32'(bus.Count), 32'(i));
        end
        step(1'b0, 1'b0, 2'd0, 8'h00);
        chk("idle_dvld", 32'(bus.DoutValid), 0);
        chk("drain_empty", 32'(bus.Empty), 1);
        chk("drain_topvalid", 32'(bus.TopValid), 0);
        chk("drain_top", 32'(bus.Top), 0);

        // Pop held at empty
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'd0, 8'h00);
            chk("unf_hit", 32'(bus.UnfHit), 1);
            chk("unf_count", 32'(bus.Count), 0);
        end
        chk("unf_addrerr", 32'(bus.AddrErr), 0);
        step(1'b0, 1'b0, 2'd0, 8'h00);
        chk("unf_clear", 32'(bus.UnfHit), 0);

        // Refill with A0..A3 then hold push at addr 3
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'(i), 8'hA0 + 8'(i));
        chk("refill_count", 32'(bus.Count), 4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'd3, 8'hEE);
            chk("ovf_hit", 32'(bus.OvfHit), 1);
            chk("ovf_count", 32'(bus.Count), 4);
            chk("ovf_top", 32'(bus.Top), 32'h00A3);
        end
        chk("ovf_addrerr", 32'(bus.AddrErr), 0);
        step(1'b0, 1'b0, 2'd0, 8'h00);
        chk("ovf_clear", 32'(bus.OvfHit), 0);

        // Down to count 2, then a misaddressed push
        step(1'b0, 1'b1, 2'd3, 8'h00);
        chk("pop_a3", 32'(bus.Dout), 32'h00A3);
        step(1'b0, 1'b1, 2'd2, 8'h00);
        chk("pop_a2", 32'(bus.Dout), 32'h00A2);
        step(1'b1, 1'b0, 2'd3, 8'h5A);
        chk("aerr_set", 32'(bus.AddrErr), 1);
        chk("aerr_count", 32'(bus.Count), 2);
        chk("aerr_top", 32'(bus.Top), 32'h00A1);
        step(1'b1, 1'b0, 2'd2, 8'h55);
        chk("aerr_recover_count", 32'(bus.Count), 3);
        chk("aerr_recover_top", 32'(bus.Top), 32'h0055);
        chk("aerr_sticky", 32'(bus.AddrErr), 1);

        // Push at DEPTH-1 followed immediately by pop
        step(1'b1, 1'b0, 2'd3, 8'h66);
        chk("b2b_full", 32'(bus.Full), 1);
        step(1'b0, 1'b1, 2'd3, 8'h00);
        chk("b2b_dout", 32'(bus.Dout), 32'h0066);
        chk("b2b_dvld", 32'(bus.DoutValid), 1);
        step(1'b0, 1'b1, 2'd2, 8'h00);
        chk("b2b_pop55", 32'(bus.Dout), 32'h0055);
        step(1'b0, 1'b1, 2'd1, 8'h00);
        chk("b2b_popA1", 32'(bus.Dout), 32'h00A1);
        chk("b2b_count", 32'(bus.Count), 1);

        // push and pop together
        step(1'b1, 1'b1, 2'd0, 8'h77);
        chk("proto_set", 32'(bus.ProtoErr), 1);
        chk("proto_count", 32'(bus.Count), 1);
        chk("proto_dvld", 32'(bus.DoutValid), 0);
        chk("proto_top", 32'(bus.Top), 32'h00A0);

        // Async reset mid-cycle at count 3
        step(1'b1, 1'b0, 2'd1, 8'h77);
        step(1'b1, 1'b0, 2'd2, 8'h88);
        chk("pre_rst_count", 32'(bus.Count), 3);
        #2;
        Rst = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0;
        #1;
        chk("async_rst_count", 32'(bus.Count), 0);
        chk("async_rst_empty", 32'(bus.Empty), 1);
        chk("async_rst_top", 32'({bus.TopValid, bus.Top}), 0);
        chk("async_rst_dout", 32'(bus.Dout), 0);
        chk("async_rst_flags", 32'({bus.AddrErr, bus.ProtoErr, bus.OvfHit, bus.UnfHit, bus.DoutValid}), 0);
        @(negedge Clk);
        Rst = 1'b0;
        step(1'b1, 1'b0, 2'd0, 8'h99);
        chk("post_rst_count", 32'(bus.Count), 1);
        chk("post_rst_top", 32'(bus.Top), 32'h0099);
        chk("post_rst_aerr", 32'(bus.AddrErr), 0);
        step(1'b0, 1'b0, 2'd0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_store.md
Name: stack_store

Overview:
- Storage end of the four-entry push/pop stack protocol.
- The push/pop controller drives `push`, `pop` and the address pair `A1`/`A0` on the falling edge of `Clk`.
- This block samples those signals on the rising edge, holds the data entries, checks each command against its own occupancy count, and returns popped data and the current top-of-stack.
- It sits directly behind the controller in the stack datapath.

Parameters:
- `DATA_W`, default 8, width of each stored entry.
- `DEPTH`, default 4, number of entries; fixed to the 2-bit address space (must be at most 4).
- `CNT_W`, default 3, width of the occupancy count (holds 0..`DEPTH`).

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `push`  in  1  push command (level, sampled each rising edge).
- `pop`  in  1  pop command (level, sampled each rising edge).
- `A1`  in  1  address bit 1 from the controller.
- `A0`  in  1  address bit 0 from the controller.
- `Din`  in  `DATA_W`  data to write on push.
- `Dout`  out  `DATA_W`  data read by the last accepted pop (registered).
- `DoutValid`  out  1  one-cycle pulse: `Dout` updated this cycle.
- `Top`  out  `DATA_W`  entry at `count-1`; 0 when empty.
- `TopValid`  out  1  high when `count` != 0.
- `Count`  out  `CNT_W`  current occupancy.
- `Full`  out  1  `Count == DEPTH`.
- `Empty`  out  1  `Count == 0`.
- `OvfHit`  out  1  registered; high for the cycle after a push was rejected because the stack was full.
- `UnfHit`  out  1  registered; high for the cycle after a pop was rejected because the stack was empty.
- `AddrErr`  out  1  sticky; address disagreed with `Count` on an otherwise legal command.
- `ProtoErr`  out  1  sticky; `push` and `pop` sampled high together.

Behaviour:
- Reset (async, `Rst`=1): `Count`=0, `Dout`=0, `DoutValid`=0, `OvfHit`=0, `UnfHit`=0, `AddrErr`=0, `ProtoErr`=0, all entries cleared to 0. Outputs hold these values while `Rst` is high. A reset mid-sequence discards all contents.
- Let `addr = {A1,A0}`. All inputs are sampled on the rising edge of `Clk`. The controller changes them on the falling edge, giving a half-cycle setup.
- Command decode, one per rising edge, evaluated in this priority order:
  - `push`=1 and `pop`=1: set `ProtoErr`; no write, no read, `Count` unchanged.
  - `push`=1, `Count==DEPTH`: no write; `OvfHit`=1 next cycle; `AddrErr` not touched. This covers the controller holding `push` with a stale address while saturated.
  - `push`=1, `addr != Count`: set `AddrErr`; no write.
  - `push`=1, `addr == Count`: write `mem[addr] <= Din`; `Count+1`.
  - `pop`=1, `Count==0`: no read; `UnfHit`=1 next cycle; `AddrErr` not touched. This covers `pop` held at empty.
  - `pop`=1, `addr != Count-1`: set `AddrErr`; no read.
  - `pop`=1, `addr == Count-1`: `Dout <= mem[addr]`; `DoutValid`=1 for exactly one cycle; `Count-1`. The entry content is left in place (not cleared).
  - Neither asserted: idle.
- `DoutValid`, `OvfHit` and `UnfHit` are cleared on every rising edge where their condition does not recur. A repeated rejected command therefore keeps the flag high continuously.
- Output timing:
  - `Top`, `TopValid`, `Full`, `Empty` are combinational from `Count` and the entry storage.
  - A write is visible on `Top` in the cycle after the accepting edge.
  - Read latency is 1 cycle: `Dout` and `DoutValid` change on the accepting edge.
- Consecutive commands: one command per cycle, back-to-back supported, no bubbles. A push at `DEPTH-1` followed immediately by a pop returns the just-written data.
- `AddrErr` and `ProtoErr` clear only on `Rst`.
- `Count` never leaves 0..`DEPTH` under any input sequence.

Decomposition:
- Shared package `stack_pkg`:
  - constants `STACK_DEPTH`=4, `STACK_ADDR_W`=2, `STACK_DATA_W`=8, `STACK_CNT_W`=3;
  - command enum `{CMD_IDLE, CMD_PUSH, CMD_POP, CMD_BOTH}` built from `{push,pop}`.
- One natural sub-module: `stack_cmd_check`. It is combinational and takes `push`, `pop`, `addr`, `Count`, producing accept_push, accept_pop, ovf, unf, addr_err, proto_err. It is instantiated here and reusable by the bench scoreboard.
- Storage array and registers stay in `stack_store`.

Test Plan:
- Reset, then four pushes at addr 0,1,2,3 with `Din` = 0x11,0x22,0x33,0x44 -> `Count` 1..4; `Full`=1; `Top`=0x44; no error flags.
- From full, four pops at addr 3,2,1,0 -> `Dout` = 0x44,0x33,0x22,0x11, each with a one-cycle `DoutValid`; `Empty`=1; `TopValid`=0.
- Full, hold `push`=1 at addr 3 for 3 cycles -> `OvfHit` high 3 cycles; `Count` stays 4; `AddrErr`=0. Symmetric: empty, `pop` held at addr 0 -> `UnfHit` high; `Count`=0.
- `Count`=2, push with addr=3 -> `AddrErr`=1 and stays set; `Count`=2; `Top` unchanged. Subsequent legal push at addr 2 still succeeds.
- `push`=`pop`=1 at `Count`=1 -> `ProtoErr`=1; `Count`=1; no `DoutValid`.
- Assert `Rst` asynchronously mid-cycle at `Count`=3 with `AddrErr`=1 -> all outputs immediately 0 (`Empty`=1). After release, a push at addr 0 is accepted.
